// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: machine width, default vectors and the
// sequencer state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_EXC_VECTOR   = 32'h0000_0080;
  localparam logic [XLEN-1:0] DEF_PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle: instruction-memory req/ack channel plus the
// valid/stall channel towards decode. The master is the sequencer.
interface pc_sequencer_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            stall;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  stall
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output stall
  );

endinterface

// File: rtl/pc_sequencer_redirect_arb.sv
// Redirect arbiter: picks exception over branch and turns a misaligned
// branch target into an exception to EXC_VECTOR. Purely combinational.
module redirect_arb
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic            exc_req,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            redir_valid,
  output logic            redir_exc,
  output logic [XLEN-1:0] redir_target,
  output logic            fault
);

  logic misaligned;

  assign misaligned = (branch_target[1:0] != 2'b00);

  // Priority select; an explicit exception suppresses the branch entirely,
  // so a misaligned target only faults when the branch actually wins.
  always_comb begin
    redir_valid  = 1'b0;
    redir_exc    = 1'b0;
    redir_target = '0;
    fault        = 1'b0;
    if (exc_req) begin
      redir_valid  = 1'b1;
      redir_exc    = 1'b1;
      redir_target = EXC_VECTOR;
    end else if (branch_taken) begin
      redir_valid = 1'b1;
      if (misaligned) begin
        redir_exc    = 1'b1;
        redir_target = EXC_VECTOR;
        fault        = 1'b1;
      end else begin
        redir_target = branch_target;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the shadow PC, mirrors every update to the
// external PC register, runs the imem req/ack handshake and hands fetched
// words to decode. Redirects during an outstanding fetch squash its data.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter logic [XLEN-1:0] PC_STEP      = DEF_PC_STEP
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_sequencer_if.master  bus,
  output logic [XLEN-1:0] pc_d,
  output logic            pc_we,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            exc_req,
  output logic            fault
);

  seq_state_t      state_reg;
  logic [XLEN-1:0] pc_shadow_reg;
  logic [XLEN-1:0] pc_d_reg;
  logic            pc_we_reg;
  logic            imem_req_reg;
  logic            instr_valid_reg;
  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] instr_pc_reg;
  logic            fault_reg;
  logic            kill_reg;
  logic            pend_exc_reg;
  logic [XLEN-1:0] pend_target_reg;

  logic            redir_valid;
  logic            redir_exc;
  logic [XLEN-1:0] redir_target;
  logic            arb_fault;

  logic            take_new;
  logic [XLEN-1:0] merged_target;
  logic            merged_exc;

  redirect_arb #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .exc_req       (exc_req),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .redir_valid   (redir_valid),
    .redir_exc     (redir_exc),
    .redir_target  (redir_target),
    .fault         (arb_fault)
  );

  // Combine a new redirect with one already pending on the current fetch:
  // a pending exception is only displaced by another exception.
  always_comb begin
    take_new      = redir_valid && (redir_exc || !(kill_reg && pend_exc_reg));
    merged_target = take_new ? redir_target : pend_target_reg;
    merged_exc    = take_new ? redir_exc : pend_exc_reg;
  end

  assign bus.imem_req    = imem_req_reg;
  assign bus.imem_addr   = pc_shadow_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign pc_d            = pc_d_reg;
  assign pc_we           = pc_we_reg;
  assign fault           = fault_reg;

  // Sequencer FSM with all outputs registered; pc_we and fault are pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= S_BOOT;
      pc_shadow_reg   <= RESET_VECTOR;
      pc_d_reg        <= '0;
      pc_we_reg       <= 1'b0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      fault_reg       <= 1'b0;
      kill_reg        <= 1'b0;
      pend_exc_reg    <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      pc_we_reg <= 1'b0;
      fault_reg <= 1'b0;
      if (state_reg != S_BOOT) begin
        fault_reg <= arb_fault;
      end

      case (state_reg)
        S_BOOT: begin
          pc_shadow_reg <= RESET_VECTOR;
          pc_d_reg      <= RESET_VECTOR;
          pc_we_reg     <= 1'b1;
          imem_req_reg  <= 1'b1;
          state_reg     <= S_FETCH;
        end

        S_FETCH: begin
          if (imem_req_reg) begin
            if (bus.imem_ack) begin
              imem_req_reg <= 1'b0;
              if (kill_reg || redir_valid) begin
                // Squashed response: restart at the redirect target after
                // a one-cycle request gap.
                pc_shadow_reg <= merged_target;
                pc_d_reg      <= merged_target;
                pc_we_reg     <= 1'b1;
                kill_reg      <= 1'b0;
                pend_exc_reg  <= 1'b0;
              end else begin
                instr_reg       <= bus.imem_rdata;
                instr_pc_reg    <= pc_shadow_reg;
                instr_valid_reg <= 1'b1;
                state_reg       <= S_ISSUE;
              end
            end else if (redir_valid) begin
              // Address must stay stable until ack, so just remember it.
              kill_reg        <= 1'b1;
              pend_target_reg <= merged_target;
              pend_exc_reg    <= merged_exc;
            end
          end else begin
            // Gap cycle after a squash: nothing outstanding, redirect now.
            imem_req_reg <= 1'b1;
            if (redir_valid) begin
              pc_shadow_reg <= redir_target;
              pc_d_reg      <= redir_target;
              pc_we_reg     <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (redir_valid) begin
            pc_shadow_reg   <= redir_target;
            pc_d_reg        <= redir_target;
            pc_we_reg       <= 1'b1;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= S_FETCH;
          end else if (!bus.stall) begin
            pc_shadow_reg   <= pc_shadow_reg + PC_STEP;
            pc_d_reg        <= pc_shadow_reg + PC_STEP;
            pc_we_reg       <= 1'b1;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b1;
            state_reg       <= S_FETCH;
          end
        end

        default: begin
          state_reg <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_d;
  logic        pc_we;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exc_req;
  logic        fault;
  int          errors = 0;
  int          checks = 0;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .pc_d          (pc_d),
    .pc_we         (pc_we),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exc_req       (exc_req),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; exc_req = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.stall = 1'b0;
    repeat (3) tick();
    checks++; if ({pc_we, bus.imem_req, bus.instr_valid, fault} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {pc_we, bus.imem_req, bus.instr_valid, fault}); end
    checks++; if ({pc_d, bus.instr, bus.instr_pc} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", pc_d, bus.instr, bus.instr_pc); end
    reset_n = 1'b1;
    tick();
    checks++; if (pc_we !== 1'b1 || pc_d !== 32'h0) begin errors++; $display("FAIL boot_write: got we=%b pc_d=%h want we=1 pc_d=0", pc_we, pc_d); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL boot_req: got req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
    tick();
    bus.imem_ack = 1'b0;
    checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 32'h13, 32'h0}) begin errors++; $display("FAIL first_instr: got v=%b i=%h pc=%h want 1/13/0", bus.instr_valid, bus.instr, bus.instr_pc); end
    checks++; if (bus.imem_req !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("FAIL first_idle: got req=%b we=%b want 0/0", bus.imem_req, pc_we); end
    $display("txn reset: instr=%h pc=%h", bus.instr, bus.instr_pc);
  endtask

  task automatic test_sequential();
    logic [31:0] data;
    for (int k = 1; k <= 3; k++) begin
      bus.stall = 1'b0;
      tick();
      bus.stall = 1'b1;
      checks++; if (pc_we !== 1'b1 || pc_d !== 32'(4 * k)) begin errors++; $display("FAIL seq_pcd%0d: got we=%b pc_d=%h want 1/%h", k, pc_we, pc_d, 32'(4 * k)); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k) || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL seq_req%0d: got req=%b addr=%h v=%b", k, bus.imem_req, bus.imem_addr, bus.instr_valid); end
      data = $urandom;
      bus.imem_ack = 1'b1; bus.imem_rdata = data;
      tick();
      bus.imem_ack = 1'b0;
      checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc, pc_we} !== {1'b1, data, 32'(4 * k), 1'b0}) begin errors++; $display("FAIL seq_instr%0d: got v=%b i=%h pc=%h we=%b want 1/%h/%h/0", k, bus.instr_valid, bus.instr, bus.instr_pc, pc_we, data, 32'(4 * k)); end
      $display("txn seq: instr=%h pc=%h", bus.instr, bus.instr_pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] i0, p0;
    bus.stall = 1'b1;
    i0 = bus.instr; p0 = bus.instr_pc;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc, pc_we, bus.imem_req} !== {1'b1, i0, p0, 2'b00}) begin errors++; $display("FAIL stall_hold%0d: got v=%b i=%h pc=%h we=%b req=%b want 1/%h/%h/0/0", k, bus.instr_valid, bus.instr, bus.instr_pc, pc_we, bus.imem_req, i0, p0); end
    end
  endtask

  task automatic test_branch_kill();
    bus.stall = 1'b0;
    tick();
    bus.stall = 1'b1;
    checks++; if (bus.imem_addr !== 32'h10 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL kill_start: got req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr); end
    tick();
    branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    branch_taken = 1'b0; branch_target = 32'h0;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10 || pc_we !== 1'b0) begin errors++; $display("FAIL kill_hold: got req=%b addr=%h we=%b want 1/10/0", bus.imem_req, bus.imem_addr, pc_we); end
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    checks++; if ({bus.instr_valid, pc_we, pc_d, bus.imem_req} !== {1'b0, 1'b1, 32'h200, 1'b0}) begin errors++; $display("FAIL kill_drop: got v=%b we=%b pc_d=%h req=%b want 0/1/200/0", bus.instr_valid, pc_we, pc_d, bus.imem_req); end
    tick();
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL kill_refetch: got req=%b addr=%h v=%b want 1/200/0", bus.imem_req, bus.imem_addr, bus.instr_valid); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0050_0093;
    tick();
    bus.imem_ack = 1'b0;
    checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 32'h0050_0093, 32'h200}) begin errors++; $display("FAIL kill_instr: got v=%b i=%h pc=%h want 1/00500093/200", bus.instr_valid, bus.instr, bus.instr_pc); end
    $display("txn branch: instr=%h pc=%h", bus.instr, bus.instr_pc);
  endtask

  task automatic test_exc_priority();
    bus.stall = 1'b1;
    exc_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    exc_req = 1'b0; branch_taken = 1'b0;
    checks++; if ({pc_we, pc_d, bus.instr_valid, fault} !== {1'b1, 32'h80, 1'b0, 1'b0}) begin errors++; $display("FAIL exc_prio: got we=%b pc_d=%h v=%b fault=%b want 1/80/0/0", pc_we, pc_d, bus.instr_valid, fault); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin errors++; $display("FAIL exc_req_addr: got req=%b addr=%h want 1/80", bus.imem_req, bus.imem_addr); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3000_0073;
    tick();
    bus.imem_ack = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h302;
    tick();
    branch_taken = 1'b0; branch_target = 32'h0;
    checks++; if ({fault, pc_we, pc_d, bus.instr_valid} !== {1'b1, 1'b1, 32'h80, 1'b0}) begin errors++; $display("FAIL misalign: got fault=%b we=%b pc_d=%h v=%b want 1/1/80/0", fault, pc_we, pc_d, bus.instr_valid); end
    tick();
    checks++; if (fault !== 1'b0 || pc_we !== 1'b0) begin errors++; $display("FAIL fault_pulse: got fault=%b we=%b want 0/0", fault, pc_we); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3000_0073;
    tick();
    bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h80) begin errors++; $display("FAIL exc_instr: got v=%b pc=%h want 1/80", bus.instr_valid, bus.instr_pc); end
    $display("txn exc: instr=%h pc=%h", bus.instr, bus.instr_pc);
  endtask

  task automatic test_wrap_and_reset();
    bus.stall = 1'b1;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0; branch_target = 32'h0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
    tick();
    bus.imem_ack = 1'b0;
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got v=%b pc=%h want 1/fffffffc", bus.instr_valid, bus.instr_pc); end
    bus.stall = 1'b0;
    tick();
    bus.stall = 1'b1;
    checks++; if (pc_we !== 1'b1 || pc_d !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap: got we=%b pc_d=%h addr=%h want 1/0/0", pc_we, pc_d, bus.imem_addr); end
    reset_n = 1'b0;
    tick();
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL midfetch_reset: got req=%b v=%b want 0/0", bus.imem_req, bus.instr_valid); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    tick();
    reset_n = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    checks++; if ({pc_we, pc_d, bus.imem_req, bus.imem_addr, bus.instr_valid} !== {1'b1, 32'h0, 1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL reboot: got we=%b pc_d=%h req=%b addr=%h v=%b", pc_we, pc_d, bus.imem_req, bus.imem_addr, bus.instr_valid); end
    tick();
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL late_ack: got v=%b req=%b want 0/1", bus.instr_valid, bus.imem_req); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0000_0013;
    tick();
    bus.imem_ack = 1'b0;
    checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 32'h13, 32'h0}) begin errors++; $display("FAIL reboot_instr: got v=%b i=%h pc=%h want 1/13/0", bus.instr_valid, bus.instr, bus.instr_pc); end
  endtask

  // Model: the bench is the memory, so it knows when a fetch is outstanding.
  // The architectural next PC advances by 4 on a consume and jumps on a
  // redirect; during an outstanding fetch a branch cannot displace an earlier
  // exception, and the squashed fetch writes the PC when it is acked.
  task automatic test_random(input int ncycles);
    logic [31:0] exp_pc, cur_addr, hold_instr, hold_pc, exp_pcd, exp_data, r_tgt, tgt;
    bit out, kill, pend_exc, exp_we, exp_fault, exp_deliver, exp_drop, exp_hold;
    bit r_valid, r_exc, r_fault, ack;
    int lat, idle, kind;
    exp_pc = 32'h0; cur_addr = 32'h0; hold_instr = 32'h13; hold_pc = 32'h0;
    exp_pcd = 32'h0; exp_data = 32'h0; out = 0; kill = 0; pend_exc = 0; lat = 0; idle = 0;
    exp_we = 0; exp_fault = 0; exp_deliver = 0; exp_drop = 0; exp_hold = 0;
    for (int c = 0; c < ncycles; c++) begin
      checks++; if (pc_we !== exp_we) begin errors++; $display("FAIL rnd_we c%0d: got %b want %b", c, pc_we, exp_we); end
      if (exp_we) begin
        checks++; if (pc_d !== exp_pcd) begin errors++; $display("FAIL rnd_pcd c%0d: got %h want %h", c, pc_d, exp_pcd); end
      end
      checks++; if (fault !== exp_fault) begin errors++; $display("FAIL rnd_fault c%0d: got %b want %b", c, fault, exp_fault); end
      if (exp_deliver) begin
        checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, exp_data, cur_addr}) begin errors++; $display("FAIL rnd_instr c%0d: got v=%b i=%h pc=%h want 1/%h/%h", c, bus.instr_valid, bus.instr, bus.instr_pc, exp_data, cur_addr); end
        hold_instr = exp_data; hold_pc = cur_addr;
        $display("txn rnd: instr=%h pc=%h", exp_data, cur_addr);
      end
      if (exp_drop) begin
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_drop c%0d: got v=%b want 0", c, bus.instr_valid); end
      end
      if (exp_hold) begin
        checks++; if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, hold_instr, hold_pc}) begin errors++; $display("FAIL rnd_hold c%0d: got v=%b i=%h pc=%h want 1/%h/%h", c, bus.instr_valid, bus.instr, bus.instr_pc, hold_instr, hold_pc); end
      end
      if (!bus.imem_req && !bus.instr_valid) idle++; else idle = 0;
      if (idle > 3) begin
        checks++; errors++;
        $display("FAIL rnd_watchdog c%0d: no request or instruction for %0d cycles, want at most 1", c, idle);
        break;
      end
      if (bus.imem_req && !out) begin
        out = 1; kill = 0; pend_exc = 0; cur_addr = exp_pc; lat = $urandom_range(0, 3);
        checks++; if (bus.imem_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.imem_addr, exp_pc); end
      end
      r_valid = 0; r_exc = 0; r_fault = 0; r_tgt = 32'h0;
      branch_taken = 1'b0; exc_req = 1'b0; branch_target = $urandom;
      if ($urandom_range(0, 99) < 12) begin
        kind = $urandom_range(0, 3);
        tgt = $urandom & 32'h0000_3FFC;
        if (kind == 2) tgt[1:0] = 2'($urandom_range(1, 3));
        branch_target = tgt;
        branch_taken = (kind != 0);
        exc_req = (kind == 0 || kind == 3);
        r_valid = 1; r_exc = (kind != 1); r_fault = (kind == 2);
        r_tgt = r_exc ? 32'h80 : tgt;
      end
      bus.stall = ($urandom_range(0, 2) == 0);
      ack = out && (lat == 0);
      if (out && lat > 0) lat--;
      bus.imem_ack = ack;
      exp_data = $urandom;
      bus.imem_rdata = exp_data;
      exp_we = 0; exp_fault = r_fault; exp_deliver = 0; exp_drop = 0; exp_hold = 0;
      if (out) begin
        if (r_valid) begin
          kill = 1;
          if (r_exc || !pend_exc) exp_pc = r_tgt;
          if (r_exc) pend_exc = 1;
        end
        if (ack) begin
          out = 0;
          if (kill) begin exp_we = 1; exp_pcd = exp_pc; exp_drop = 1; end
          else exp_deliver = 1;
        end
      end else if (bus.instr_valid) begin
        if (r_valid) begin exp_pc = r_tgt; exp_we = 1; exp_pcd = exp_pc; exp_drop = 1; end
        else if (!bus.stall) begin exp_pc = exp_pc + 32'd4; exp_we = 1; exp_pcd = exp_pc; exp_drop = 1; end
        else exp_hold = 1;
      end else if (r_valid) begin
        exp_pc = r_tgt; exp_we = 1; exp_pcd = exp_pc;
      end
      tick();
    end
    branch_taken = 1'b0; exc_req = 1'b0; bus.imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_kill();
    test_exc_priority();
    test_wrap_and_reset();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controls the program counter for the fetch stage. It computes next-PC, drives the write port of the PC register and runs a req/ack handshake with instruction memory. It delivers fetched instructions to decode under a stall/valid handshake. Redirects (exception > branch) may arrive at any time; an in-flight fetch is squashed.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on the first cycle after reset release
EXC_VECTOR, 32'h0000_0080, redirect target for exc_req and misaligned targets
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  system clock, all state updates on posedge
reset_n  in  1  synchronous active-low reset
pc_d  out  32  next-PC value to PC register data input
pc_we  out  1  PC register write enable, one-cycle pulse
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  32  fetch address, stable while imem_req=1
imem_ack  in  1  memory response valid, imem_rdata valid same cycle
imem_rdata  in  32  fetched instruction word
instr_valid  out  1  instr/instr_pc valid for decode
instr  out  32  instruction word
instr_pc  out  32  address of instr
stall  in  1  decode cannot accept; instr held while instr_valid=1
branch_taken  in  1  branch/jump redirect request, single-cycle
branch_target  in  32  redirect target, sampled when branch_taken=1
exc_req  in  1  exception redirect request, single-cycle
fault  out  1  one-cycle pulse: misaligned branch_target converted to exception

Behaviour:
- Reset (reset_n=0 at posedge): state=S_BOOT; pc_shadow=RESET_VECTOR; pc_we=0, pc_d=0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, fault=0; pending-redirect and kill flags cleared. Reset mid-fetch abandons the transaction; a late imem_ack is ignored.
- pc_shadow is the internal PC copy. imem_addr=pc_shadow. pc_d/pc_we mirror every pc_shadow update to the PC register, on the cycle it is written.
- S_BOOT: pc_we=1, pc_d=RESET_VECTOR for one cycle -> S_FETCH.
- S_FETCH: imem_req=1. On imem_ack with kill=0: latch instr=imem_rdata, instr_pc=pc_shadow, instr_valid=1 -> S_ISSUE. On imem_ack with kill=1: drop data, pc_shadow=pending target, pc_we=1, clear kill, imem_req=0 for that cycle, stay S_FETCH (new request next cycle).
- S_ISSUE: instr_valid=1. If stall=0: consume instr; pc_shadow=pc_shadow+PC_STEP (mod 2^32, 32'hFFFF_FFFC wraps to 0); pc_we=1; instr_valid=0 next cycle -> S_FETCH. If stall=1: hold all outputs.
- Redirect priority: exc_req > branch_taken > sequential.
  - In S_ISSUE: apply immediately; pc_shadow=target, pc_we=1, instr_valid=0 next cycle -> S_FETCH. This also applies under stall.
  - In S_FETCH without ack: set kill=1 and store the target as pending. A later exc_req overwrites a pending branch; a later branch does not overwrite a pending exception; a later branch overwrites a pending branch.
  - Redirect in the same cycle as imem_ack: treated as kill=1 for that response.
  - Redirect in S_BOOT: ignored.
- Misaligned branch_target (bits[1:0]!=0): treated as exc_req with target EXC_VECTOR; fault=1 for one cycle.
- Latency: ack at cycle N -> instr_valid at N+1. Consume at M -> imem_req at M+1. Minimum 3 cycles per instruction with 1-cycle-ack memory.
- imem_req never deasserts before ack except on reset.

Decomposition:
- Shared package cpu_pkg: state enum (S_BOOT, S_FETCH, S_ISSUE), RESET_VECTOR/EXC_VECTOR defaults, XLEN=32, PC_STEP.
- Sub-module redirect_arb: combinational priority select and misalignment check. Outputs redir_valid, redir_target, fault.
- The existing pc_register is instantiated beside this block, not inside it.

Test Plan:
- Reset release, ack after 1 cycle with rdata=32'h00000013 -> pc_we=1/pc_d=0 in boot cycle; imem_addr=0; instr_valid=1, instr=32'h00000013, instr_pc=0.
- Three consumes, stall=0 -> pc_d sequence 4, 8, 12; imem_addr follows; one pc_we pulse each.
- stall=1 for 5 cycles in S_ISSUE -> instr/instr_pc/instr_valid stable, no pc_we, no imem_req.
- branch_taken target=32'h200 two cycles into a 4-cycle-latency fetch at 0x10 -> returned word discarded (instr_valid stays 0); pc_d=32'h200; next imem_addr=32'h200.
- exc_req and branch_taken same cycle in S_ISSUE (target 32'h300) -> pc_d=32'h80, instr_valid drops; branch_target=32'h302 alone -> fault pulse, pc_d=32'h80.
- pc_shadow=32'hFFFF_FFFC consumed -> pc_d=0; reset_n=0 during outstanding fetch -> S_BOOT, late ack ignored, next request at RESET_VECTOR.
